// File: rtl/watch_mode_ctrl.sv
// Digital-watch mode controller: decodes short/long presses of the mode button and
// routes the remaining buttons to the stopwatch or to the time-set datapath.
module watch_mode_ctrl #(
    parameter int unsigned LONG_PRESS_CYC  = 100_000_000,
    parameter int unsigned SET_TIMEOUT_CYC = 1_000_000_000,
    parameter int unsigned BLINK_CYC       = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_mode,
    input  logic       i_btn_l,
    input  logic       i_btn_r,
    input  logic       i_btn_u,
    input  logic       i_btn_d,
    input  logic       i_sw_running,
    output logic [1:0] o_mode,
    output logic       o_sw_runstop,
    output logic       o_sw_clear,
    output logic [1:0] o_set_field,
    output logic       o_set_inc,
    output logic       o_set_dec,
    output logic       o_set_commit,
    output logic       o_set_abort,
    output logic       o_blink
);

    localparam int PRESS_W = $clog2(LONG_PRESS_CYC + 1);
    localparam int TO_W    = $clog2(SET_TIMEOUT_CYC + 1);
    localparam int BLINK_W = $clog2(BLINK_CYC + 1);

    typedef enum logic [1:0] {
        MODE_WATCH     = 2'd0,
        MODE_STOPWATCH = 2'd1,
        MODE_SET       = 2'd2
    } mode_t;

    mode_t              state, state_nxt;
    logic [1:0]         field, field_nxt;
    logic               blink, blink_nxt;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_nxt;
    logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
    logic [PRESS_W-1:0] press_cnt;
    logic               long_fired;
    logic               btn_prev;
    logic               runstop_nxt, clear_nxt, inc_nxt, dec_nxt, commit_nxt, abort_nxt;

    logic long_evt, short_evt, mode_evt, activity, timeout_evt;

    // A long event fires once per press; a release after it is swallowed.
    assign long_evt    = i_btn_mode && (press_cnt == PRESS_W'(LONG_PRESS_CYC - 1));
    assign short_evt   = btn_prev && !i_btn_mode && !long_fired;
    assign mode_evt    = long_evt || short_evt;
    assign activity    = i_btn_mode | i_btn_l | i_btn_r | i_btn_u | i_btn_d;
    assign timeout_evt = (state == MODE_SET) && (to_cnt == TO_W'(SET_TIMEOUT_CYC - 1));

    assign o_mode      = state;
    assign o_set_field = field;
    assign o_blink     = blink;

    always_comb begin
        state_nxt     = state;
        field_nxt     = field;
        blink_nxt     = 1'b0;
        blink_cnt_nxt = '0;
        to_cnt_nxt    = '0;
        runstop_nxt   = 1'b0;
        clear_nxt     = 1'b0;
        inc_nxt       = 1'b0;
        dec_nxt       = 1'b0;
        commit_nxt    = 1'b0;
        abort_nxt     = 1'b0;

        case (state)
            MODE_WATCH: begin
                if (long_evt) begin
                    state_nxt = MODE_SET;
                    field_nxt = 2'd0;
                    blink_nxt = 1'b1;
                end else if (short_evt) begin
                    state_nxt = MODE_STOPWATCH;
                end
            end
            MODE_STOPWATCH: begin
                if (mode_evt) begin
                    state_nxt = MODE_WATCH;
                end else begin
                    runstop_nxt = i_btn_r;
                    clear_nxt   = i_btn_l && !i_btn_r && !i_sw_running;
                end
            end
            MODE_SET: begin
                if (mode_evt) begin
                    commit_nxt = 1'b1;
                    state_nxt  = MODE_WATCH;
                end else if (timeout_evt) begin
                    abort_nxt = 1'b1;
                    state_nxt = MODE_WATCH;
                end else begin
                    to_cnt_nxt = activity ? '0 : to_cnt + TO_W'(1);
                    inc_nxt    = i_btn_u && !i_btn_d;
                    dec_nxt    = i_btn_d && !i_btn_u;
                    // Any field move restarts the blink so the new field is shown lit.
                    if (i_btn_l ^ i_btn_r) begin
                        if (i_btn_l)
                            field_nxt = (field == 2'd0) ? 2'd2 : field - 2'd1;
                        else
                            field_nxt = (field == 2'd2) ? 2'd0 : field + 2'd1;
                        blink_nxt = 1'b1;
                    end else if (blink_cnt == BLINK_W'(BLINK_CYC - 1)) begin
                        blink_nxt = ~blink;
                    end else begin
                        blink_nxt     = blink;
                        blink_cnt_nxt = blink_cnt + BLINK_W'(1);
                    end
                end
            end
            default: state_nxt = MODE_WATCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= MODE_WATCH;
            field        <= 2'd0;
            blink        <= 1'b0;
            blink_cnt    <= '0;
            to_cnt       <= '0;
            press_cnt    <= '0;
            long_fired   <= 1'b0;
            btn_prev     <= 1'b0;
            o_sw_runstop <= 1'b0;
            o_sw_clear   <= 1'b0;
            o_set_inc    <= 1'b0;
            o_set_dec    <= 1'b0;
            o_set_commit <= 1'b0;
            o_set_abort  <= 1'b0;
        end else begin
            state        <= state_nxt;
            field        <= field_nxt;
            blink        <= blink_nxt;
            blink_cnt    <= blink_cnt_nxt;
            to_cnt       <= to_cnt_nxt;
            btn_prev     <= i_btn_mode;
            o_sw_runstop <= runstop_nxt;
            o_sw_clear   <= clear_nxt;
            o_set_inc    <= inc_nxt;
            o_set_dec    <= dec_nxt;
            o_set_commit <= commit_nxt;
            o_set_abort  <= abort_nxt;
            if (!i_btn_mode) begin
                press_cnt  <= '0;
                long_fired <= 1'b0;
            end else begin
                if (press_cnt != PRESS_W'(LONG_PRESS_CYC))
                    press_cnt <= press_cnt + PRESS_W'(1);
                if (long_evt)
                    long_fired <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Directed bench for watch_mode_ctrl with short timing parameters.
module tb_watch_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode, btn_l, btn_r, btn_u, btn_d, sw_running;
    logic [1:0] mode;
    logic       sw_runstop, sw_clear, set_inc, set_dec, set_commit, set_abort, blink;
    logic [1:0] set_field;

    int checks = 0;
    int errors = 0;

    watch_mode_ctrl #(
        .LONG_PRESS_CYC (100),
        .SET_TIMEOUT_CYC(500),
        .BLINK_CYC      (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_btn_mode  (btn_mode),
        .i_btn_l     (btn_l),
        .i_btn_r     (btn_r),
        .i_btn_u     (btn_u),
        .i_btn_d     (btn_d),
        .i_sw_running(sw_running),
        .o_mode      (mode),
        .o_sw_runstop(sw_runstop),
        .o_sw_clear  (sw_clear),
        .o_set_field (set_field),
        .o_set_inc   (set_inc),
        .o_set_dec   (set_dec),
        .o_set_commit(set_commit),
        .o_set_abort (set_abort),
        .o_blink     (blink)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic m, input logic l, input logic r,
                                 input logic u, input logic d);
        btn_mode = m;
        btn_l    = l;
        btn_r    = r;
        btn_u    = u;
        btn_d    = d;
        tick();
    endtask

    task automatic holdMode(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulse vector order: runstop, clear, inc, dec, commit, abort.
    function automatic logic [5:0] pulses();
        return {sw_runstop, sw_clear, set_inc, set_dec, set_commit, set_abort};
    endfunction

    initial begin
        $display("[TB] start");
        rst = 1'b0;
        sw_running = 1'b0;
        btn_mode = 1'b1; btn_l = 1'b1; btn_r = 1'b1; btn_u = 1'b1; btn_d = 1'b1;
        repeat (3) tick();
        checkOutput("rst_mode", mode, 2'd0);
        checkOutput("rst_field", set_field, 2'd0);
        checkOutput("rst_pulses", pulses(), 6'b000000);
        checkOutput("rst_blink", blink, 1'b0);

        rst = 1'b1;
        idle(1);
        checkOutput("post_rst_mode", mode, 2'd0);
        checkOutput("post_rst_pulses", pulses(), 6'b000000);

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("watch_ignore_btns", pulses(), 6'b000000);

        holdMode(50);
        checkOutput("short_hold_mode", mode, 2'd0);
        idle(1);
        checkOutput("short1_mode", mode, 2'd1);
        holdMode(50);
        idle(1);
        checkOutput("short2_mode", mode, 2'd0);
        holdMode(50);
        idle(1);
        checkOutput("short3_mode", mode, 2'd1);

        $display("[TB] stopwatch commands");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("sw_runstop_pulse", pulses(), 6'b100000);
        idle(1);
        checkOutput("sw_runstop_end", pulses(), 6'b000000);
        sw_running = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("sw_clear_running", pulses(), 6'b000000);
        sw_running = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("sw_clear_stopped", pulses(), 6'b010000);
        idle(1);
        checkOutput("sw_clear_end", pulses(), 6'b000000);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("sw_lr_together", pulses(), 6'b100000);

        holdMode(50);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("sw_exit_mode", mode, 2'd0);
        checkOutput("sw_exit_suppress", pulses(), 6'b000000);

        $display("[TB] long press");
        holdMode(99);
        checkOutput("long_before", mode, 2'd0);
        holdMode(1);
        checkOutput("long_mode", mode, 2'd2);
        checkOutput("long_blink", blink, 1'b1);
        checkOutput("long_field", set_field, 2'd0);
        checkOutput("long_pulses", pulses(), 6'b000000);
        holdMode(49);
        idle(1);
        checkOutput("long_release_mode", mode, 2'd2);
        checkOutput("long_release_pulses", pulses(), 6'b000000);

        $display("[TB] set editing");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("field_l_wrap", set_field, 2'd2);
        checkOutput("field_l_blink", blink, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("field_r_wrap", set_field, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("field_r_min", set_field, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("field_r_hour", set_field, 2'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("set_inc", pulses(), 6'b001000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("set_ud_none", pulses(), 6'b000000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("set_dec", pulses(), 6'b000100);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("field_lr_hold", set_field, 2'd2);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("field_l_min", set_field, 2'd1);
        idle(19);
        checkOutput("blink_still_on", blink, 1'b1);
        idle(1);
        checkOutput("blink_toggle", blink, 1'b0);

        holdMode(50);
        idle(1);
        checkOutput("commit_pulse", pulses(), 6'b000010);
        checkOutput("commit_mode", mode, 2'd0);
        checkOutput("commit_blink", blink, 1'b0);
        idle(1);
        checkOutput("commit_end", pulses(), 6'b000000);

        $display("[TB] set timeout");
        holdMode(100);
        checkOutput("to_enter", mode, 2'd2);
        idle(400);
        checkOutput("to_mid_mode", mode, 2'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("to_u_inc", pulses(), 6'b001000);
        idle(499);
        checkOutput("to_before_mode", mode, 2'd2);
        checkOutput("to_before_pulses", pulses(), 6'b000000);
        idle(1);
        checkOutput("to_abort", pulses(), 6'b000001);
        checkOutput("to_abort_mode", mode, 2'd0);
        idle(1);
        checkOutput("to_abort_end", pulses(), 6'b000000);

        $display("[TB] reset inside set");
        holdMode(100);
        checkOutput("rst_set_enter", mode, 2'd2);
        rst = 1'b0;
        idle(1);
        checkOutput("rst_set_mode", mode, 2'd0);
        checkOutput("rst_set_pulses", pulses(), 6'b000000);
        checkOutput("rst_set_blink", blink, 1'b0);
        rst = 1'b1;
        idle(1);
        checkOutput("rst_set_after", pulses(), 6'b000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
